// File: rtl/dipsw_debounce.sv
// ============================================================================
//  Module      : dipsw_debounce
//  Description : Input conditioner for the DIP switch bank. Each switch bit
//                passes through a 2-flop synchroniser into clk_50M. It is
//                then debounced on a shared sample tick. The block publishes
//                a stable switch word and a valid/ready change-event stream
//                that carries the mask of bits flipped since the last
//                accepted event.
//  Ports       : clk_50M    in   system clock
//                resetn     in   asynchronous active-low reset
//                dip_sw_raw in   raw switch levels (asynchronous)
//                sw_stable  out  debounced switch word
//                chg_valid  out  change event pending (|chg_mask)
//                chg_ready  in   consumer accepts the pending event
//                chg_mask   out  bits flipped since last accepted event
//                irq        out  change interrupt
//  Config      : DIPSW_IRQ_EN - when defined, irq is chg_valid delayed by
//                one cycle; otherwise irq is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dipsw_debounce #(
    parameter int               WIDTH        = 32,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 4,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic             clk_50M,
    input  logic             resetn,
    input  logic [WIDTH-1:0] dip_sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             chg_valid,
    input  logic             chg_ready,
    output logic [WIDTH-1:0] chg_mask,
    output logic             irq
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W  = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

    localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(STABLE_TICKS - 1);

    logic [WIDTH-1:0]  r_sync1;
    logic [WIDTH-1:0]  r_sync2;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic [WIDTH-1:0]  r_stable;
    logic [WIDTH-1:0]  w_flip;
    logic [WIDTH-1:0]  r_mask;
    logic [WIDTH-1:0]  w_mask_nxt;
    logic              w_accept;

    // ------------------------------------------------------------------
    // Two-flop synchroniser.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= dip_sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Shared sample tick: one cycle in every TICK_DIV.
    // ------------------------------------------------------------------
    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk_50M or negedge resetn) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce counters. A counter advances only on ticks where
    // the synchronised level differs from the published level. Any
    // agreeing tick clears it, so short glitches never accumulate.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] r_cnt;
        logic             w_diff;

        assign w_diff    = r_sync2[i] ^ r_stable[i];
        assign w_flip[i] = w_tick & w_diff & (r_cnt == c_cnt_last);

        always_ff @(posedge clk_50M or negedge resetn) begin
            if (!resetn) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                if (!w_diff || (r_cnt == c_cnt_last)) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_50M or negedge resetn) begin
        if (!resetn) begin
            r_stable <= RESET_VAL;
        end else begin
            r_stable <= r_stable ^ w_flip;
        end
    end

    // ------------------------------------------------------------------
    // Change-event mask. An accept clears the old mask, but a flip that
    // lands in the same cycle is OR-ed back in, so it is never lost.
    // chg_valid is decoded from the mask register alone, which leaves no
    // combinational path from chg_ready.
    // ------------------------------------------------------------------
    assign w_accept   = chg_valid & chg_ready;
    assign w_mask_nxt = (w_accept ? '0 : r_mask) | w_flip;

    always_ff @(posedge clk_50M or negedge resetn) begin
        if (!resetn) begin
            r_mask <= '0;
        end else begin
            r_mask <= w_mask_nxt;
        end
    end

    assign sw_stable = r_stable;
    assign chg_mask  = r_mask;
    assign chg_valid = |r_mask;

`ifdef DIPSW_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk_50M or negedge resetn) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= chg_valid;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dipsw_debounce.sv
// ============================================================================
//  Module      : tb_dipsw_debounce
//  Description : Directed self-checking bench for dipsw_debounce with
//                TICK_DIV=4, STABLE_TICKS=3, RESET_VAL=0. A small phase
//                counter mirrors the tick period, so stimulus can be lined
//                up with a specific tick edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dipsw_debounce;

    localparam int WIDTH = 32;

    logic             clk_50M = 1'b0;
    logic             resetn  = 1'b0;
    logic [WIDTH-1:0] dip_sw_raw = '0;
    logic [WIDTH-1:0] sw_stable;
    logic             chg_valid;
    logic             chg_ready = 1'b0;
    logic [WIDTH-1:0] chg_mask;
    logic             irq;

    int n_cmp = 0;
    int n_err = 0;
    int ph    = 0;

`ifdef DIPSW_IRQ_EN
    localparam logic c_irq_on = 1'b1;
`else
    localparam logic c_irq_on = 1'b0;
`endif

    dipsw_debounce #(
        .WIDTH        (WIDTH),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .RESET_VAL    ('0)
    ) dut (
        .clk_50M    (clk_50M),
        .resetn     (resetn),
        .dip_sw_raw (dip_sw_raw),
        .sw_stable  (sw_stable),
        .chg_valid  (chg_valid),
        .chg_ready  (chg_ready),
        .chg_mask   (chg_mask),
        .irq        (irq)
    );

    always #5 clk_50M = ~clk_50M;

    // Tick phase model: the next edge is a tick edge when ph == 3.
    always @(posedge clk_50M) begin
        if (!resetn) ph <= 0;
        else         ph <= (ph == 3) ? 0 : ph + 1;
    end

    task automatic step;
        @(posedge clk_50M);
        #1;
    endtask

    task automatic test_reset;
        resetn     = 1'b0;
        dip_sw_raw = 32'hFFFF_FFFF;
        chg_ready  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if (sw_stable !== 32'h0) begin
                n_err++; $display("FAIL reset_sw_stable: got %h want %h", sw_stable, 32'h0);
            end
            n_cmp++;
            if (chg_valid !== 1'b0) begin
                n_err++; $display("FAIL reset_chg_valid: got %b want 0", chg_valid);
            end
            n_cmp++;
            if (chg_mask !== 32'h0) begin
                n_err++; $display("FAIL reset_chg_mask: got %h want %h", chg_mask, 32'h0);
            end
            n_cmp++;
            if (irq !== 1'b0) begin
                n_err++; $display("FAIL reset_irq: got %b want 0", irq);
            end
        end
    endtask

    task automatic test_latency;
        int  k;
        bit  found;
        dip_sw_raw = 32'h0;
        resetn     = 1'b1;
        dip_sw_raw = 32'h4;
        k     = 0;
        found = 1'b0;
        while (!found && k < 40) begin
            step();
            k++;
            if (sw_stable === 32'h4) found = 1'b1;
        end
        n_cmp++;
        if (!found || k < 11 || k > 14) begin
            n_err++; $display("FAIL latency: got found=%0b cycle=%0d want cycle in 11..14", found, k);
        end
        n_cmp++;
        if (chg_valid !== 1'b1) begin
            n_err++; $display("FAIL latency_valid: got %b want 1", chg_valid);
        end
        n_cmp++;
        if (chg_mask !== 32'h4) begin
            n_err++; $display("FAIL latency_mask: got %h want %h", chg_mask, 32'h4);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL irq_same_cycle: got %b want 0", irq);
        end
        step();
        n_cmp++;
        if (irq !== c_irq_on) begin
            n_err++; $display("FAIL irq_next_cycle: got %b want %b", irq, c_irq_on);
        end
        chg_ready = 1'b1;
        step();
        chg_ready = 1'b0;
        n_cmp++;
        if (chg_valid !== 1'b0 || chg_mask !== 32'h0) begin
            n_err++; $display("FAIL latency_accept: got valid=%b mask=%h want valid=0 mask=0", chg_valid, chg_mask);
        end
    endtask

    task automatic test_glitch;
        dip_sw_raw = 32'h5;
        for (int c = 0; c < 8; c++) begin
            step();
            n_cmp++;
            if (sw_stable !== 32'h4 || chg_valid !== 1'b0) begin
                n_err++; $display("FAIL glitch_high: got sw=%h valid=%b want sw=%h valid=0", sw_stable, chg_valid, 32'h4);
            end
        end
        dip_sw_raw = 32'h4;
        for (int c = 0; c < 30; c++) begin
            step();
            n_cmp++;
            if (sw_stable !== 32'h4 || chg_valid !== 1'b0) begin
                n_err++; $display("FAIL glitch_after: got sw=%h valid=%b want sw=%h valid=0", sw_stable, chg_valid, 32'h4);
            end
        end
    endtask

    task automatic test_handshake;
        int k;
        int nt;
        dip_sw_raw = 32'h0;
        k = 0;
        while (sw_stable[2] !== 1'b0 && k < 20) begin
            step();
            k++;
        end
        n_cmp++;
        if (sw_stable !== 32'h0 || chg_mask !== 32'h4 || chg_valid !== 1'b1) begin
            n_err++; $display("FAIL hs_pending: got sw=%h mask=%h valid=%b want sw=0 mask=4 valid=1", sw_stable, chg_mask, chg_valid);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            n_cmp++;
            if (chg_valid !== 1'b1 || chg_mask !== 32'h4) begin
                n_err++; $display("FAIL hs_hold: got valid=%b mask=%h want valid=1 mask=4", chg_valid, chg_mask);
            end
        end
        chg_ready = 1'b1;
        step();
        chg_ready = 1'b0;
        n_cmp++;
        if (chg_valid !== 1'b0 || chg_mask !== 32'h0) begin
            n_err++; $display("FAIL hs_accept: got valid=%b mask=%h want valid=0 mask=0", chg_valid, chg_mask);
        end

        // Second round: bit1 flips in the same cycle as the accept.
        dip_sw_raw = 32'h4;
        k = 0;
        while (sw_stable !== 32'h4 && k < 20) begin
            step();
            k++;
        end
        n_cmp++;
        if (sw_stable !== 32'h4 || chg_mask !== 32'h4) begin
            n_err++; $display("FAIL hs_pending2: got sw=%h mask=%h want sw=4 mask=4", sw_stable, chg_mask);
        end
        dip_sw_raw = 32'h6;
        k  = 0;
        nt = 0;
        while (nt < 3 && k < 40) begin
            if (k >= 2 && ph == 3) begin
                nt++;
                if (nt == 3) begin
                    n_cmp++;
                    if (chg_mask !== 32'h4 || chg_valid !== 1'b1) begin
                        n_err++; $display("FAIL hs_pre_accept: got mask=%h valid=%b want mask=4 valid=1", chg_mask, chg_valid);
                    end
                    chg_ready = 1'b1;
                end
            end
            step();
            k++;
        end
        chg_ready = 1'b0;
        n_cmp++;
        if (nt != 3 || sw_stable !== 32'h6 || chg_valid !== 1'b1 || chg_mask !== 32'h2) begin
            n_err++; $display("FAIL hs_flip_in_accept: got ticks=%0d sw=%h valid=%b mask=%h want ticks=3 sw=6 valid=1 mask=2",
                              nt, sw_stable, chg_valid, chg_mask);
        end
        chg_ready = 1'b1;
        step();
        chg_ready = 1'b0;
        n_cmp++;
        if (chg_valid !== 1'b0) begin
            n_err++; $display("FAIL hs_accept2: got valid=%b want 0", chg_valid);
        end
    endtask

    task automatic test_reset_mid;
        int k;
        int nt;
        dip_sw_raw = 32'hE;
        k  = 0;
        nt = 0;
        while (nt < 2 && k < 40) begin
            if (k >= 2 && ph == 3) nt++;
            step();
            k++;
        end
        n_cmp++;
        if (sw_stable !== 32'h6 || chg_valid !== 1'b0) begin
            n_err++; $display("FAIL rm_partial: got sw=%h valid=%b want sw=6 valid=0", sw_stable, chg_valid);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (sw_stable !== 32'h0 || chg_valid !== 1'b0 || chg_mask !== 32'h0 || irq !== 1'b0) begin
            n_err++; $display("FAIL rm_async_reset: got sw=%h valid=%b mask=%h irq=%b want all 0",
                              sw_stable, chg_valid, chg_mask, irq);
        end
        step();
        resetn = 1'b1;
        k  = 0;
        nt = 0;
        while (nt < 3 && k < 40) begin
            if (k >= 2 && ph == 3) nt++;
            step();
            k++;
            if (nt < 3) begin
                n_cmp++;
                if (sw_stable !== 32'h0 || chg_valid !== 1'b0) begin
                    n_err++; $display("FAIL rm_early: got sw=%h valid=%b want sw=0 valid=0", sw_stable, chg_valid);
                end
            end
        end
        n_cmp++;
        if (nt != 3 || sw_stable !== 32'hE || chg_valid !== 1'b1 || chg_mask !== 32'hE) begin
            n_err++; $display("FAIL rm_redetect: got ticks=%0d sw=%h valid=%b mask=%h want ticks=3 sw=e valid=1 mask=e",
                              nt, sw_stable, chg_valid, chg_mask);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_handshake();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
